// File: rtl/multiply_add.sv
// -----------------------------------------------------------------------------
// multiply_add
// Sequential shift-and-add multiply-accumulate: P = Q*D + R (unsigned, full
// 2*WIDTH-bit result). This is the inverse of the restoring divider, so N
// reproduces the dividend whenever R < D.
//
// One operation takes WIDTH RUN cycles plus one DONE cycle; with start held
// high a new operation is accepted every WIDTH+2 cycles.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new operation (accepted only when idle)
//   Q      in   WIDTH   multiplier (quotient) operand
//   D      in   WIDTH   multiplicand (divisor) operand
//   R      in   WIDTH   addend (remainder) operand
//   N      out  WIDTH   low half of the result
//   P      out  2*WIDTH full result
//   ovf    out  high when the upper half of P is nonzero
//   busy   out  high while the multiply is iterating
//   done   out  one-cycle pulse when P/N/ovf are updated
// -----------------------------------------------------------------------------
module multiply_add #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     Q,
   input  logic [WIDTH-1:0]     D,
   input  logic [WIDTH-1:0]     R,
   output logic [WIDTH-1:0]     N,
   output logic [2*WIDTH-1:0]   P,
   output logic                 ovf,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_r;
   logic [WIDTH-1:0]     mul_r;     // multiplier, consumed LSB first
   logic [WIDTH-1:0]     d_r;       // latched multiplicand
   logic [2*WIDTH-1:0]   acc_r;     // running sum, seeded with R
   logic [CW-1:0]        cnt_r;     // step index = current shift amount
   logic [2*WIDTH-1:0]   addend_s;

   // Partial product for the current step: D aligned to the bit being consumed.
   assign addend_s = {{WIDTH{1'b0}}, d_r} << cnt_r;

   // Control FSM, datapath and registered outputs.
   // busy/done are registered from the current state, so they trail the state
   // by one edge: busy covers the WIDTH cycles after the RUN edges begin, and
   // done coincides with the cycle in which P/N/ovf first show the new result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         mul_r   <= {WIDTH{1'b0}};
         d_r     <= {WIDTH{1'b0}};
         acc_r   <= {(2*WIDTH){1'b0}};
         cnt_r   <= {CW{1'b0}};
         P       <= {(2*WIDTH){1'b0}};
         N       <= {WIDTH{1'b0}};
         ovf     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  mul_r   <= Q;
                  d_r     <= D;
                  acc_r   <= {{WIDTH{1'b0}}, R};
                  cnt_r   <= {CW{1'b0}};
                  state_r <= RUN;
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               busy <= 1'b1;
               done <= 1'b0;
               if (mul_r[0]) begin
                  acc_r <= acc_r + addend_s;
               end else begin
                  acc_r <= acc_r;
               end
               mul_r <= mul_r >> 1;
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == LAST_STEP) begin
                  state_r <= DONE;
               end else begin
                  state_r <= RUN;
               end
            end
            DONE: begin
               busy    <= 1'b0;
               done    <= 1'b1;
               P       <= acc_r;
               N       <= acc_r[WIDTH-1:0];
               ovf     <= |acc_r[2*WIDTH-1:WIDTH];
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiply_add.sv
// -----------------------------------------------------------------------------
// tb_multiply_add
// Self-checking bench for multiply_add (WIDTH=16): a table of directed vectors
// with hand-computed results, plus sequences for start-during-RUN, reset abort
// and back-to-back operation with start held high.
// -----------------------------------------------------------------------------
module tb_multiply_add;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   Q, D, R;
   logic [W-1:0]   N;
   logic [2*W-1:0] P;
   logic           ovf, busy, done;

   int n_checks = 0;
   int n_fail   = 0;
   logic [2*W-1:0] prev_p;

   multiply_add #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .Q     (Q),
      .D     (D),
      .R     (R),
      .N     (N),
      .P     (P),
      .ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   q;
      logic [W-1:0]   d;
      logic [W-1:0]   r;
      logic [2*W-1:0] p;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation with a start pulse and wait (bounded) for done.
   // n_edges = edges from the start edge to the edge after which done is seen
   // (0 on timeout). P must keep hold_p while the operation runs.
   task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] d,
                         input logic [W-1:0] r, input logic [2*W-1:0] hold_p,
                         input bit poke, output int n_edges, output int n_busy);
      Q = q; D = d; R = r; start = 1'b1;
      tick();
      start   = 1'b0;
      n_edges = 0;
      n_busy  = 0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (busy) n_busy++;
         if (n == 8) check("p_hold_during_run", P, hold_p);
         if (poke && n == 4) begin
            Q = 16'hFFFF; D = 16'hFFFF; R = 16'h1111; start = 1'b1;
         end
         if (poke && n == 5) start = 1'b0;
         if (done) begin
            n_edges = n;
            break;
         end
      end
   endtask

   task automatic do_vec(input logic [W-1:0] q, input logic [W-1:0] d,
                         input logic [W-1:0] r, input logic [2*W-1:0] exp_p, input bit poke);
      int ne, nb;
      run_op(q, d, r, prev_p, poke, ne, nb);
      check("done_latency", 64'(ne), 64'd17);
      check("busy_cycles", 64'(nb), 64'd16);
      check("P", P, exp_p);
      check("N", N, exp_p[W-1:0]);
      check("ovf", ovf, |exp_p[2*W-1:W]);
      prev_p = exp_p;
   endtask

   initial begin
      int extra_done;
      int n;
      logic [W-1:0]   rq, rd, rr;
      logic [2*W-1:0] exp_p;

      vecs[0] = '{q: 16'h0007, d: 16'h0003, r: 16'h0002, p: 32'h0000_0017};
      vecs[1] = '{q: 16'h0019, d: 16'h000A, r: 16'h0003, p: 32'h0000_00FD};
      vecs[2] = '{q: 16'hFFFF, d: 16'hFFFF, r: 16'hFFFF, p: 32'hFFFF_0000};
      vecs[3] = '{q: 16'h1234, d: 16'h0000, r: 16'h00AB, p: 32'h0000_00AB};
      vecs[4] = '{q: 16'h0000, d: 16'h0005, r: 16'h0003, p: 32'h0000_0003};
      vecs[5] = '{q: 16'h0100, d: 16'h0100, r: 16'h0000, p: 32'h0001_0000};
      vecs[6] = '{q: 16'h1234, d: 16'h0010, r: 16'h0005, p: 32'h0001_2345};

      // Reset state
      rst_n = 1'b0; start = 1'b0; Q = '0; D = '0; R = '0;
      prev_p = '0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("reset_P", P, 64'd0);
      check("reset_N", N, 64'd0);
      check("reset_ovf", ovf, 64'd0);
      check("reset_busy", busy, 64'd0);
      check("reset_done", done, 64'd0);

      // Directed vector table
      for (int i = 0; i < 7; i++) begin
         do_vec(vecs[i].q, vecs[i].d, vecs[i].r, vecs[i].p, 1'b0);
      end

      // Operand change and start pulse during RUN must not disturb the result
      do_vec(16'h1234, 16'h0000, 16'h00AB, 32'h0000_00AB, 1'b1);
      extra_done = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (done) extra_done++;
      end
      check("no_extra_done", 64'(extra_done), 64'd0);
      check("P_after_poke", P, 64'h0000_00AB);

      // Reset in the middle of RUN aborts without a done pulse
      Q = 16'h0019; D = 16'h000A; R = 16'h0003; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      check("busy_before_abort", busy, 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_P", P, 64'd0);
      check("abort_N", N, 64'd0);
      check("abort_ovf", ovf, 64'd0);
      check("abort_busy", busy, 64'd0);
      check("abort_done", done, 64'd0);
      extra_done = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done) extra_done++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) extra_done++;
      end
      check("abort_no_done", 64'(extra_done), 64'd0);
      prev_p = '0;
      do_vec(16'h0007, 16'h0003, 16'h0002, 32'h0000_0017, 1'b0);

      // Back-to-back operations with start held high
      rd = 16'($urandom_range(1, 255));
      rq = 16'($urandom_range(0, 255));
      rr = 16'($urandom_range(0, 32'(rd) - 1));
      Q = rq; D = rd; R = rr; start = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         exp_p = 32'(rq) * 32'(rd) + 32'(rr);
         n = 0;
         for (int c = 1; c <= 40; c++) begin
            tick();
            if (done) begin
               n = c;
               break;
            end
         end
         check("b2b_spacing", 64'(n), (i == 0) ? 64'd17 : 64'd18);
         check("b2b_N_dividend", N, exp_p[W-1:0]);
         check("b2b_ovf", ovf, 64'd0);
         if (i < 5) begin
            rd = 16'($urandom_range(1, 255));
            rq = 16'($urandom_range(0, 255));
            rr = 16'($urandom_range(0, 32'(rd) - 1));
            Q = rq; D = rd; R = rr;
         end else begin
            start = 1'b0;
         end
      end
      tick(); tick();
      check("idle_after_b2b", busy, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multiply_add.md
MULTIPLY_ADD -- requirements
Module: multiply_add

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand width in bits; all widths below scale with it.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation, sampled on the rising edge of clk.
REQ-005 The block SHALL have port Q, input, WIDTH bits: quotient operand, unsigned.
REQ-006 The block SHALL have port D, input, WIDTH bits: divisor operand, unsigned.
REQ-007 The block SHALL have port R, input, WIDTH bits: remainder operand, unsigned.
REQ-008 The block SHALL have port N, output, WIDTH bits: reconstructed dividend, equal to P[WIDTH-1:0].
REQ-009 The block SHALL have port P, output, 2*WIDTH bits: full result, Q*D+R.
REQ-010 The block SHALL have port ovf, output, 1 bit: high when P[2*WIDTH-1:WIDTH] is nonzero.
REQ-011 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.

Function
REQ-013 The block SHALL compute P = Q*D + R, unsigned, with no truncation in P; this is the inverse of the team's restoring divider, so N = dividend whenever R < D.
REQ-014 The block SHALL implement states IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 SHALL latch Q, D and R into internal registers, load the accumulator with R zero-extended to 2*WIDTH bits, clear the step counter, and move to RUN.
REQ-016 In RUN, each cycle SHALL add (D_reg shifted left by the step count) to the accumulator if bit 0 of the multiplier shift register is 1; the shift register SHALL then shift right one place and the counter SHALL increment.
REQ-017 After exactly WIDTH RUN cycles, the block SHALL move to DONE and write the accumulator to P, N and ovf.
REQ-018 DONE SHALL last one cycle with done=1; the block SHALL then return to IDLE.
REQ-019 Latency: if start is sampled at edge k, busy SHALL be 1 from edge k+1 through k+WIDTH, and done SHALL be 1 in the cycle after edge k+WIDTH+1.
REQ-020 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; busy and done SHALL never be high together.
REQ-021 start SHALL be ignored in RUN and DONE; operand changes after the latch SHALL NOT affect the result.
REQ-022 P, N and ovf SHALL hold their last values until the next DONE and SHALL NOT change during RUN.
REQ-023 start held high continuously SHALL start back-to-back operations, each re-latched in IDLE, one every WIDTH+2 cycles.
REQ-024 Boundary D=0 or Q=0: P SHALL equal R and ovf SHALL be 0.
REQ-025 Boundary all ones: the result SHALL wrap into P's upper half; for WIDTH=16, P=0xFFFF0000, N=0x0000, ovf=1.

Reset
REQ-026 rst_n=0 SHALL, asynchronously and in any state, force IDLE and clear P, N, ovf, busy, done, the accumulator and the counter to 0.
REQ-027 A reset during RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave as in REQ-015.

Verification (WIDTH=16)
REQ-028 Bench: Q=0x0007, D=0x0003, R=0x0002, start pulse -> done in the cycle after edge k+17, N=0x0017, P=0x00000017, ovf=0.
REQ-029 Bench: Q=0x0019, D=0x000A, R=0x0003 -> N=0x00FD, ovf=0; busy high for exactly 16 cycles.
REQ-030 Bench: Q=0xFFFF, D=0xFFFF, R=0xFFFF -> P=0xFFFF0000, N=0x0000, ovf=1.
REQ-031 Bench: D=0x0000, Q=0x1234, R=0x00AB -> N=0x00AB, ovf=0; then change the operands and pulse start during RUN -> result unaffected and no extra done.
REQ-032 Bench: rst_n low at RUN cycle 8 -> all outputs 0 immediately, no done pulse; the next start completes correctly.
REQ-033 Bench: random Q, D<>0, R<D, with start held high -> every done has N equal to the reference divider's dividend, and done pulses are spaced 18 cycles apart.
